// File: rtl/addr_dispatch.sv
// Pops host requests from the hold buffer, tracks the open row of every bank and
// issues PRE/ACT/RD/WR commands over a valid/ready handshake; closes all banks for refresh.
module addr_dispatch #(
  parameter int BANK_W = 3,
  parameter int ROW_W  = 14,
  parameter int COL_W  = 10,
  parameter int ADDR_W = BANK_W + ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              hb_valid,
  input  logic [ADDR_W-1:0] hb_addr,
  input  logic              hb_we,
  output logic              hb_pop,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_op,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [COL_W-1:0]  cmd_col,
  input  logic              refresh_req,
  output logic              refresh_ack,
  output logic [2:0]        dbg_state_o
);

  localparam int NB = 1 << BANK_W;
  localparam logic [1:0] OP_PRE = 2'd0;
  localparam logic [1:0] OP_ACT = 2'd1;
  localparam logic [1:0] OP_RD  = 2'd2;
  localparam logic [1:0] OP_WR  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PRE, S_ACT, S_ACCESS, S_REF_SCAN, S_REF_PRE, S_REF_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BANK_W-1:0]   idx_q, idx_d;
  logic [BANK_W-1:0]   req_bank_q;
  logic [ROW_W-1:0]    req_row_q;
  logic [COL_W-1:0]    req_col_q;
  logic                req_we_q;
  logic [NB-1:0]       open_q, open_d;
  logic [ROW_W-1:0]    row_tab_q [NB];
  logic                row_wr, row_clr;
  logic [1:0]          op_q, op_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                hs;
  logic                row_hit;

  // Handshake: a command transfers on a rising clk edge where cmd_valid and cmd_ready
  // are both high; cmd_* stay frozen while cmd_valid is high and cmd_ready is low.
  assign cmd_valid   = (state_q == S_PRE) || (state_q == S_ACT) ||
                       (state_q == S_ACCESS) || (state_q == S_REF_PRE);
  assign hs          = cmd_valid & cmd_ready;
  assign hb_pop      = hb_valid & (state_q == S_IDLE) & ~refresh_req;
  assign refresh_ack = (state_q == S_REF_DONE);
  assign cmd_op      = op_q;
  assign cmd_bank    = bank_q;
  assign cmd_row     = row_q;
  assign cmd_col     = col_q;
  assign dbg_state_o = state_q;
  assign row_hit     = open_q[req_bank_q] && (row_tab_q[req_bank_q] == req_row_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    open_d  = open_q;
    row_wr  = 1'b0;
    row_clr = 1'b0;
    op_d    = op_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (refresh_req) begin
          state_d = S_REF_SCAN;
          idx_d   = '0;
        end else if (hb_valid) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        bank_d = req_bank_q;
        row_d  = req_row_q;
        col_d  = req_col_q;
        if (row_hit) begin
          state_d = S_ACCESS;
          op_d    = req_we_q ? OP_WR : OP_RD;
        end else if (open_q[req_bank_q]) begin
          state_d = S_PRE;
          op_d    = OP_PRE;
        end else begin
          state_d = S_ACT;
          op_d    = OP_ACT;
        end
      end
      S_PRE: begin
        if (hs) begin
          open_d[req_bank_q] = 1'b0;
          state_d = S_ACT;
          op_d    = OP_ACT;
        end
      end
      S_ACT: begin
        if (hs) begin
          open_d[req_bank_q] = 1'b1;
          row_wr  = 1'b1;
          state_d = S_ACCESS;
          op_d    = req_we_q ? OP_WR : OP_RD;
        end
      end
      S_ACCESS: begin
        if (hs) state_d = S_IDLE;
      end
      S_REF_SCAN: begin
        // Closed banks are skipped in a single cycle without issuing anything.
        if (open_q[idx_q]) begin
          state_d = S_REF_PRE;
          op_d    = OP_PRE;
          bank_d  = idx_q;
        end else if (idx_q == '1) begin
          state_d = S_REF_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_REF_PRE: begin
        if (hs) begin
          open_d[idx_q] = 1'b0;
          if (idx_q == '1) begin
            state_d = S_REF_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_REF_SCAN;
          end
        end
      end
      S_REF_DONE: begin
        open_d  = '0;
        row_clr = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      open_q  <= '0;
      op_q    <= '0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      open_q  <= open_d;
      op_q    <= op_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Host address layout is {row, bank, col} with the column in the LSBs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_bank_q <= '0;
      req_row_q  <= '0;
      req_col_q  <= '0;
      req_we_q   <= 1'b0;
    end else if (hb_pop) begin
      req_col_q  <= hb_addr[COL_W-1:0];
      req_bank_q <= hb_addr[COL_W +: BANK_W];
      req_row_q  <= hb_addr[COL_W+BANK_W +: ROW_W];
      req_we_q   <= hb_we;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NB; i++) row_tab_q[i] <= '0;
    end else if (row_clr) begin
      for (int i = 0; i < NB; i++) row_tab_q[i] <= '0;
    end else if (row_wr) begin
      row_tab_q[req_bank_q] <= req_row_q;
    end
  end

endmodule

// File: tb/tb_addr_dispatch.sv
// Bench for addr_dispatch: directed scenarios plus randomized requests, checked against
// an open-row table model that predicts the command stream of every transaction.
module tb_addr_dispatch;

  localparam int BW = 3;
  localparam int RW = 14;
  localparam int CW = 10;
  localparam int AW = BW + RW + CW;
  localparam int NB = 8;
  localparam int KW = 29;
  localparam int OP_PRE = 0;
  localparam int OP_ACT = 1;
  localparam int OP_RD  = 2;
  localparam int OP_WR  = 3;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          hb_valid = 1'b0;
  logic [AW-1:0] hb_addr = '0;
  logic          hb_we = 1'b0;
  logic          hb_pop;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [1:0]    cmd_op;
  logic [BW-1:0] cmd_bank;
  logic [RW-1:0] cmd_row;
  logic [CW-1:0] cmd_col;
  logic          refresh_req = 1'b0;
  logic          refresh_ack;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [KW-1:0] exp_q[$];
  bit m_open[NB];
  int m_row[NB];

  always #5 clk = ~clk;

  addr_dispatch dut (
    .clk(clk), .n_rst(n_rst),
    .hb_valid(hb_valid), .hb_addr(hb_addr), .hb_we(hb_we), .hb_pop(hb_pop),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .refresh_req(refresh_req), .refresh_ack(refresh_ack), .dbg_state_o(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Only the fields that matter for each opcode take part in the comparison.
  function automatic logic [KW-1:0] key(input int op, input int bank, input int row, input int col);
    int r = (op == OP_ACT) ? row : 0;
    int c = (op >= OP_RD) ? col : 0;
    return KW'(op * (1 << 27) + bank * (1 << 24) + r * (1 << 10) + c);
  endfunction

  function automatic logic [KW-1:0] obs_key();
    return key(int'(cmd_op), int'(cmd_bank), int'(cmd_row), int'(cmd_col));
  endfunction

  function automatic int mk_addr(input int row, input int bank, input int col);
    return row * (1 << (BW + CW)) + bank * (1 << CW) + col;
  endfunction

  function automatic int head_op();
    logic [KW-1:0] hd;
    if (exp_q.size() == 0) return -1;
    hd = exp_q[0];
    return int'(hd) / (1 << 27);
  endfunction

  task automatic model_req(input int addr, input bit we);
    int b = (addr / (1 << CW)) % NB;
    int r = addr / (1 << (BW + CW));
    int c = addr % (1 << CW);
    int acc = we ? OP_WR : OP_RD;
    if (!(m_open[b] && m_row[b] == r)) begin
      if (m_open[b]) exp_q.push_back(key(OP_PRE, b, 0, 0));
      exp_q.push_back(key(OP_ACT, b, r, 0));
    end
    exp_q.push_back(key(acc, b, 0, c));
    m_open[b] = 1'b1;
    m_row[b]  = r;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pop"}, hb_pop, 0);
    chk({tag, "_valid"}, cmd_valid, 0);
    chk({tag, "_ack"}, refresh_ack, 0);
    chk({tag, "_fields"}, {cmd_op, cmd_bank, cmd_row, cmd_col}, 0);
  endtask

  task automatic run_req(input int addr, input bit we, input int stall_pct, input int act_stall,
                         input bit ref_mid, input bit abort);
    int since = 0;
    int stall_left = act_stall;
    bit seen = 0;
    bit done = 0;
    bit prev_stall = 0;
    logic [KW-1:0] prev_raw = '0;
    logic [KW-1:0] want;
    model_req(addr, we);
    @(negedge clk);
    hb_valid = 1'b1; hb_addr = AW'(addr); hb_we = we; cmd_ready = 1'b1;
    #1;
    chk("pop", hb_pop, 1);
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      since++;
      hb_valid = 1'($urandom_range(0, 1));
      hb_addr  = AW'($urandom);
      hb_we    = 1'($urandom_range(0, 1));
      if (ref_mid) refresh_req = 1'b1;
      if (abort && exp_q.size() == 1) cmd_ready = 1'b0;
      else if (stall_left > 0 && head_op() == OP_ACT) cmd_ready = 1'b0;
      else cmd_ready = ($urandom_range(0, 99) >= stall_pct);
      #1;
      chk("no_pop_busy", hb_pop, 0);
      chk("no_ack_busy", refresh_ack, 0);
      if (prev_stall) begin
        chk("held_valid", cmd_valid, 1);
        chk("held_fields", {cmd_op, cmd_bank, cmd_row, cmd_col}, prev_raw);
      end
      if (!seen) begin
        if (cmd_valid) begin
          seen = 1;
          chk("first_cmd_latency", since, 2);
        end
      end else begin
        chk("valid_continuous", cmd_valid, 1);
      end
      if (cmd_valid && !cmd_ready && stall_left > 0 && head_op() == OP_ACT) stall_left--;
      if (abort && cmd_valid && exp_q.size() == 1) begin
        hb_valid = 1'b0; refresh_req = 1'b0;
        @(negedge clk);
        chk("abort_held", cmd_valid, 1);
        #2 n_rst = 1'b0;
        #1;
        chk_reset_outs("abort_rst");
        exp_q.delete();
        for (int b = 0; b < NB; b++) m_open[b] = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        done = 1;
      end else begin
        prev_stall = cmd_valid && !cmd_ready;
        prev_raw   = {cmd_op, cmd_bank, cmd_row, cmd_col};
        if (cmd_valid && cmd_ready) begin
          chk("cmd_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            chk("cmd", obs_key(), want);
          end
          if (exp_q.size() == 0) done = 1;
        end
      end
    end
    chk("txn_done", done, 1);
    @(negedge clk);
    hb_valid = ref_mid; cmd_ready = 1'b1;
    #1;
    if (ref_mid) chk("ref_beats_pop", hb_pop, 0);
  endtask

  task automatic do_refresh(input int stall_pct);
    bit done = 0;
    bit prev_stall = 0;
    logic [KW-1:0] prev_raw = '0;
    logic [KW-1:0] want;
    for (int b = 0; b < NB; b++) if (m_open[b]) exp_q.push_back(key(OP_PRE, b, 0, 0));
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      refresh_req = (cyc == 0);
      hb_valid    = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      hb_addr     = AW'($urandom);
      cmd_ready   = ($urandom_range(0, 99) >= stall_pct);
      #1;
      chk("ref_no_pop", hb_pop, 0);
      if (prev_stall) chk("ref_held", {cmd_valid, cmd_op, cmd_bank, cmd_row, cmd_col}, {1'b1, prev_raw});
      prev_stall = cmd_valid && !cmd_ready;
      prev_raw   = {cmd_op, cmd_bank, cmd_row, cmd_col};
      if (cmd_valid && cmd_ready) begin
        chk("ref_cmd_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          chk("ref_pre", obs_key(), want);
        end
      end
      if (refresh_ack) begin
        chk("ack_all_closed", exp_q.size(), 0);
        done = 1;
      end
    end
    chk("ref_done", done, 1);
    exp_q.delete();
    for (int b = 0; b < NB; b++) m_open[b] = 1'b0;
    @(negedge clk);
    hb_valid = 1'b0; refresh_req = 1'b0; cmd_ready = 1'b1;
    #1;
    chk("ack_one_cycle", refresh_ack, 0);
  endtask

  initial begin
    bit rm;
    for (int b = 0; b < NB; b++) begin m_open[b] = 1'b0; m_row[b] = 0; end
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    n_rst = 1'b1;

    run_req(mk_addr(14'h123, 0, 10'h005), 1'b0, 0, 0, 1'b0, 1'b0);
    run_req(mk_addr(14'h015, 2, 10'h040), 1'b0, 0, 0, 1'b0, 1'b0);
    run_req(mk_addr(14'h015, 2, 10'h008), 1'b1, 0, 0, 1'b0, 1'b0);
    run_req(mk_addr(14'h016, 2, 10'h011), 1'b0, 0, 0, 1'b0, 1'b0);
    run_req(mk_addr(14'h200, 3, 10'h003), 1'b0, 0, 5, 1'b0, 1'b0);
    do_refresh(0);

    run_req(mk_addr(14'h015, 2, 10'h001), 1'b1, 0, 0, 1'b0, 1'b0);
    run_req(mk_addr(14'h007, 5, 10'h001), 1'b0, 0, 0, 1'b0, 1'b0);
    do_refresh(0);
    run_req(mk_addr(14'h015, 2, 10'h002), 1'b0, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rm = ($urandom_range(0, 7) == 0);
      run_req(mk_addr($urandom_range(0, 3), $urandom_range(0, NB - 1), $urandom_range(0, 1023)),
              1'($urandom_range(0, 1)), 30, $urandom_range(0, 3), rm, 1'b0);
      if (rm) do_refresh(30);
    end

    run_req(mk_addr(14'h033, 4, 10'h009), 1'b0, 0, 0, 1'b0, 1'b1);
    run_req(mk_addr(14'h033, 4, 10'h009), 1'b0, 0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
